// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS7 (x^7+x^6+1, XNOR form) checker.
package prbs_pkg;

    localparam int unsigned SR_W   = 7;
    localparam int unsigned TAP_HI = 6;
    localparam int unsigned TAP_LO = 5;
    localparam int unsigned CNT_W  = 16;

    // All-ones is the state an XNOR LFSR can never leave.
    localparam logic [SR_W-1:0] LOCKUP = 7'h7F;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/prbs7_xnor_step.sv
// One step of the PRBS7 XNOR generator: predicted next bit and advanced register.
module prbs7_xnor_step
    import prbs_pkg::*;
(
    input  logic [SR_W-1:0] sr,
    output logic            pred_c,
    output logic [SR_W-1:0] sr_next_c
);

    assign pred_c    = sr[TAP_HI] ~^ sr[TAP_LO];
    assign sr_next_c = {sr[SR_W-2:0], pred_c};

endmodule

// File: rtl/prbs7_xnor_checker.sv
// PRBS7 XNOR-form receiver checker: acquires lock, then counts bit errors
// and drops lock when too many errors land in one window.
module prbs7_xnor_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned WIN_LEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_count,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned FILL_W  = $clog2(SR_W + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned WERR_W  = $clog2(ERR_THRESH + 1);

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [FILL_W-1:0]  fill;
    logic [MATCH_W-1:0] match;
    logic [WIN_W-1:0]   win_cnt;
    logic [WERR_W-1:0]  win_err;

    logic               pred_c;
    logic [SR_W-1:0]    sr_next_c;
    logic [SR_W-1:0]    sr_shift_c;
    logic               bit_ok_c;
    logic [WERR_W-1:0]  win_err_inc_c;

    prbs7_xnor_step u_step (
        .sr        (sr),
        .pred_c    (pred_c),
        .sr_next_c (sr_next_c)
    );

    assign sr_shift_c    = {sr[SR_W-2:0], din};
    assign bit_ok_c      = din ~^ pred_c;
    assign win_err_inc_c = win_err + WERR_W'(!bit_ok_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            sr        <= '0;
            fill      <= '0;
            match     <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clr_count) begin
                err_count <= '0;
            end
            if (din_valid) begin
                unique case (state)
                    SEARCH: begin
                        sr <= sr_shift_c;
                        if (fill != FILL_W'(SR_W)) begin
                            fill <= fill + FILL_W'(1);
                        end
                        // Evaluate on the 7th fill and on every bit after while stuck in lockup.
                        if ((fill >= FILL_W'(SR_W - 1)) && (sr_shift_c != LOCKUP)) begin
                            state <= VERIFY;
                            match <= '0;
                        end
                    end
                    VERIFY: begin
                        if (bit_ok_c) begin
                            sr <= sr_shift_c;
                            if (match == MATCH_W'(LOCK_CNT - 1)) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                match   <= '0;
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                match <= match + MATCH_W'(1);
                            end
                        end else begin
                            state <= SEARCH;
                            fill  <= '0;
                            match <= '0;
                        end
                    end
                    LOCKED: begin
                        sr <= sr_next_c;
                        if (!bit_ok_c) begin
                            err_pulse <= 1'b1;
                            if (!clr_count && (err_count != '1)) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                        end
                        if (win_err_inc_c >= WERR_W'(ERR_THRESH)) begin
                            state   <= SEARCH;
                            locked  <= 1'b0;
                            fill    <= '0;
                            match   <= '0;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err_inc_c;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Directed, table-driven bench for prbs7_xnor_checker.
module tb_prbs7_xnor_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_count = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // mode: 0 = correct PRBS bit, 1 = flipped PRBS bit, 2 = constant one
    typedef struct {
        logic        valid;
        logic [1:0]  mode;
        logic        clr;
        logic        rst;
        logic        exp_locked;
        logic        exp_pulse;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vec_q[$];
    logic [6:0] gen_sr = 7'h00;

    prbs7_xnor_checker #(
        .LOCK_CNT   (16),
        .ERR_THRESH (4),
        .WIN_LEN    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr_count (clr_count),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic peek_bit();
        return gen_sr[6] ~^ gen_sr[5];
    endfunction

    task automatic next_bit(output logic b);
        b = gen_sr[6] ~^ gen_sr[5];
        gen_sr = {gen_sr[5:0], b};
    endtask

    task automatic add(input logic v, input logic [1:0] m, input logic c, input logic r,
                       input logic el, input logic ep, input logic [15:0] ec);
        vec_t t;
        t.valid = v; t.mode = m; t.clr = c; t.rst = r;
        t.exp_locked = el; t.exp_pulse = ep; t.exp_count = ec;
        vec_q.push_back(t);
    endtask

    task automatic add_run(input int n, input logic el, input logic [15:0] ec);
        for (int k = 0; k < n; k++) add(1'b1, 2'd0, 1'b0, 1'b0, el, 1'b0, ec);
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic b;
        rst       = v.rst;
        din_valid = v.valid;
        clr_count = v.clr;
        if (v.valid && v.mode != 2'd2) begin
            next_bit(b);
            din = b ^ (v.mode == 2'd1);
        end else if (v.valid) begin
            din = 1'b1;
        end else begin
            din = ~peek_bit();
        end
        @(posedge clk);
        #1;
        check("locked", idx, 16'(locked), 16'(v.exp_locked));
        check("err_pulse", idx, 16'(err_pulse), 16'(v.exp_pulse));
        check("err_count", idx, err_count, v.exp_count);
    endtask

    initial begin
        vec_t h;

        // Acquisition from reset, then a single flipped bit (bit 100)
        add(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        add(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        add_run(22, 1'b0, 16'd0);
        add(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        add_run(76, 1'b1, 16'd0);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
        add_run(2, 1'b1, 16'd1);

        // Three errors in one window hold lock; next window: preload to 5, clear, 4th drops lock
        add(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        add_run(22, 1'b0, 16'd0);
        add(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
        add_run(4, 1'b1, 16'd1);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
        add_run(4, 1'b1, 16'd2);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3);
        add_run(21, 1'b1, 16'd3);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5);
        add(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        add_run(1, 1'b0, 16'd1);

        // Re-acquire after loss of lock (one fill bit already taken), then reset mid-lock
        add_run(21, 1'b0, 16'd1);
        add(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        add_run(5, 1'b1, 16'd1);
        add(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        add_run(22, 1'b0, 16'd0);
        add(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        add_run(2, 1'b1, 16'd0);

        // All-ones stream is the XNOR lockup pattern and must never lock
        add(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 60; k++) add(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vec_q.size(); i++) apply(vec_q[i], i);

        // Gapped valid: correct bits interleaved with invalid garbage cycles
        h.mode = 2'd0; h.clr = 1'b0; h.exp_pulse = 1'b0; h.exp_count = 16'd0;
        h.valid = 1'b0; h.rst = 1'b1; h.exp_locked = 1'b0;
        apply(h, 1000);
        h.rst = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            h.valid = 1'b1; h.exp_locked = (i == 23);
            apply(h, 1000 + 2 * i);
            if (i < 23) begin
                h.valid = 1'b0; h.exp_locked = 1'b0;
                apply(h, 1001 + 2 * i);
            end
        end
        h.valid = 1'b0; h.exp_locked = 1'b1;
        apply(h, 1100);
        h.valid = 1'b1; h.mode = 2'd1; h.exp_pulse = 1'b1; h.exp_count = 16'd1;
        apply(h, 1101);
        h.valid = 1'b0; h.mode = 2'd0; h.exp_pulse = 1'b0;
        apply(h, 1102);
        h.valid = 1'b1;
        apply(h, 1103);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs7_xnor_checker.md
PRBS7_XNOR_CHECKER -- requirements
Module: prbs7_xnor_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16, meaning consecutive matching bits in VERIFY required to declare lock.
REQ-002 SHALL have parameter ERR_THRESH, default 4, meaning mismatches within one window that drop lock.
REQ-003 SHALL have parameter WIN_LEN, default 32, meaning the length in valid bits of the loss-of-lock error window.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port din, input, 1 bit, received serial bit.
REQ-007 SHALL have port din_valid, input, 1 bit, qualifies din; when low no state, counter or output changes except err_pulse returning low.
REQ-008 SHALL have port clr_count, input, 1 bit, synchronous clear of err_count.
REQ-009 SHALL have port locked, output, 1 bit, high while the FSM is in LOCKED.
REQ-010 SHALL have port err_pulse, output, 1 bit, one-cycle flag per mismatch detected in LOCKED.
REQ-011 SHALL have port err_count, output, 16 bits, saturating mismatch count.

Function
REQ-012 SHALL check the PRBS7 sequence x^7+x^6+1 in XNOR-feedback form: predicted bit = XNOR(sr[6], sr[5]); sr shifts left, new bit in sr[0].
REQ-013 SHALL compare each valid din with the predicted bit using XNOR; result 1 = match.
REQ-014 SHALL implement FSM states SEARCH, VERIFY, LOCKED.
REQ-015 SEARCH: every valid bit shifts din into sr and increments fill counter; after 7 fills, go VERIFY unless sr == 7'h7F.
REQ-016 If sr == 7'h7F (XNOR lockup pattern) after fill, SHALL stay in SEARCH and keep shifting, re-evaluating after each further valid bit.
REQ-017 VERIFY: each valid bit compared; match increments match counter and shifts din; mismatch returns to SEARCH with fill and match counters cleared.
REQ-018 VERIFY -> LOCKED on the valid bit giving LOCK_CNT consecutive matches; locked high the following cycle.
REQ-019 LOCKED: sr free-runs on the predicted bit (not din); each mismatch sets err_pulse for exactly one cycle on the cycle after the offending valid bit.
REQ-020 err_count SHALL increment per LOCKED mismatch and saturate at 16'hFFFF without wrap.
REQ-021 clr_count SHALL take precedence over a simultaneous increment; err_count becomes 0.
REQ-022 LOCKED SHALL keep window counter 0..WIN_LEN-1 and window error counter; both clear when the window wraps.
REQ-023 When window errors reach ERR_THRESH, SHALL go SEARCH the next cycle; locked low, fill/match counters cleared, err_count retained.
REQ-024 Detection latency: din sampled on cycle N -> err_pulse/locked change visible on cycle N+1; all outputs registered.

Reset
REQ-025 rst SHALL force state SEARCH, sr 0, all counters 0, locked 0, err_pulse 0, err_count 0 on the next edge, regardless of state or din_valid.
REQ-026 rst asserted mid-LOCKED SHALL require full re-acquisition (7 fill + LOCK_CNT matches).

Structure
REQ-027 SHALL place state encoding (SEARCH=0, VERIFY=1, LOCKED=2), tap positions 6 and 5, and lockup constant 7'h7F in shared package prbs_pkg.
REQ-028 SHALL instantiate one sub-module prbs7_xnor_step: combinational; 7-bit sr in, predicted bit and next sr out.

Verification
REQ-029 Reset, then 23 consecutive valid correct PRBS7 bits -> locked rises the cycle after bit 23; err_count 0.
REQ-030 Locked, flip bit 100 only -> err_pulse high one cycle, err_count 1, locked stays high.
REQ-031 Locked, flip 4 bits within one 32-bit window -> locked low the cycle after the 4th; 3 flips per window -> lock held, err_count 3.
REQ-032 60 consecutive valid ones -> locked never asserts; state remains SEARCH.
REQ-033 Correct stream with din_valid low every other cycle -> lock after 23 valid bits; invalid cycles change nothing.
REQ-034 err_count preloaded to 5, clr_count coincident with a mismatch -> err_count 0; rst mid-lock -> locked 0, err_count 0 next cycle.
